// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_mul_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_cls_e;

  function automatic int bias_of(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int word_w(int exp_w, int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int prod_w(int man_w);
    return 2 * man_w + 2;
  endfunction

  // Positive quiet NaN: exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_bits(int exp_w, int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Subnormal encodings land in ZERO: inputs are flushed.
  function automatic fp_cls_e classify(logic exp_zero, logic exp_ones, logic frac_zero);
    if (exp_zero) return ZERO;
    if (!exp_ones) return NORM;
    return frac_zero ? INF : NAN;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Final-stage combinational logic: normalise, round-to-nearest-even, special/range resolve, pack.
// Flag outputs exist only when FP_MUL_FLAGS_EN is defined.
module fp_round_norm
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  es,
  input  logic [2*MAN_W+1:0]       prod,
  input  fp_cls_e                  cls_a,
  input  fp_cls_e                  cls_b,
  output logic [EXP_W+MAN_W:0]     res
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]               flags
`endif
);
  localparam int E   = EXP_W;
  localparam int M   = MAN_W;
  localparam int ESW = EXP_W + 2;
  localparam int W   = word_w(EXP_W, MAN_W);
  localparam logic signed [E+1:0] EMAX = ESW'((1 << E) - 1);
  localparam logic [E+M:0]        QNAN = W'(qnan_bits(E, M));

  logic                msb, guard, sticky, rnd, carry;
  logic [M-1:0]        frac, frac_r;
  logic signed [E+1:0] es_n;
  logic                is_nan, is_inf, is_zero, ovf, unf;

  always_comb begin
    msb    = prod[2*M+1];
    frac   = msb ? prod[2*M:M+1] : prod[2*M-1:M];
    guard  = msb ? prod[M]       : prod[M-1];
    sticky = msb ? |prod[M-1:0]  : |prod[M-2:0];
    rnd    = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + (M+1)'(rnd);
    // A rounding carry leaves frac_r at zero, so only the exponent moves.
    es_n = es + $signed({{(E+1){1'b0}}, msb}) + $signed({{(E+1){1'b0}}, carry});
    ovf  = ~es_n[E+1] & (es_n >= EMAX);
    unf  = es_n[E+1] | (es_n == '0);

    is_nan  = (cls_a == NAN) | (cls_b == NAN) |
              ((cls_a == INF) & (cls_b == ZERO)) | ((cls_a == ZERO) & (cls_b == INF));
    is_inf  = (cls_a == INF) | (cls_b == INF);
    is_zero = (cls_a == ZERO) | (cls_b == ZERO);

    if (is_nan)       res = QNAN;
    else if (is_inf)  res = {sign, {E{1'b1}}, {M{1'b0}}};
    else if (is_zero) res = {sign, {(E+M){1'b0}}};
    else if (ovf)     res = {sign, {E{1'b1}}, {M{1'b0}}};
    else if (unf)     res = {sign, {(E+M){1'b0}}};
    else              res = {sign, es_n[E-1:0], frac_r};
  end

`ifdef FP_MUL_FLAGS_EN
  logic fin;
  always_comb begin
    fin   = ~is_nan & ~is_inf & ~is_zero;
    flags = {is_nan, fin & ovf, fin & unf, fin & (guard | sticky | ovf | unf)};
  end
`endif

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage valid/ready floating-point multiplier (unpack, multiply, round/pack).
// Define FP_MUL_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags port.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] x
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]           flags
`endif
);
  localparam int STAGES = 3;
  localparam int W      = word_w(EXP_W, MAN_W);
  localparam int PW     = prod_w(MAN_W);
  localparam int ESW    = EXP_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS_S = ESW'(bias_of(EXP_W));

  logic [STAGES:1] vld_pipe;
  logic            adv;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_cls_e          cls_a_c, cls_b_c;

  assign {ea, fa} = a[W-2:0];
  assign {eb, fb} = b[W-2:0];
  assign cls_a_c  = classify(ea == '0, &ea, fa == '0);
  assign cls_b_c  = classify(eb == '0, &eb, fb == '0);

  logic                   s1_sign, s2_sign;
  fp_cls_e                s1_cls_a, s1_cls_b, s2_cls_a, s2_cls_b;
  logic signed [ESW-1:0]  s1_es, s2_es;
  logic [MAN_W:0]         s1_ma, s1_mb;
  logic [PW-1:0]          s2_prod;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Datapath registers need no reset; results are gated by the valid pipe.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign  <= a[W-1] ^ b[W-1];
      s1_cls_a <= cls_a_c;
      s1_cls_b <= cls_b_c;
      s1_es    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
      s1_ma    <= {1'b1, fa};
      s1_mb    <= {1'b1, fb};
      s2_sign  <= s1_sign;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
      s2_es    <= s1_es;
      s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
    end
  end

  logic [W-1:0] res;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]   flg;
`endif

  fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_norm (
    .sign  (s2_sign),
    .es    (s2_es),
    .prod  (s2_prod),
    .cls_a (s2_cls_a),
    .cls_b (s2_cls_b),
    .res   (res)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags (flg)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
`ifdef FP_MUL_FLAGS_EN
      flags <= '0;
`endif
    end else if (adv) begin
      x <= vld_pipe[STAGES-1] ? res : '0;
`ifdef FP_MUL_FLAGS_EN
      flags <= vld_pipe[STAGES-1] ? flg : '0;
`endif
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: fp16 and fp32 instances checked against an arithmetic reference model.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, or16 = 1'b1, ir16, ov16;
  logic [15:0] a16 = '0, b16 = '0, x16;
  logic        iv32 = 1'b0, or32 = 1'b1, ir32, ov32;
  logic [31:0] a32 = '0, b32 = '0, x32;
  logic [3:0]  f16, f32;

`ifndef FP_MUL_FLAGS_EN
  assign f16 = 4'b0;
  assign f32 = 4'b0;
`endif

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .x(x16)
`ifdef FP_MUL_FLAGS_EN
    , .flags(f16)
`endif
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .x(x32)
`ifdef FP_MUL_FLAGS_EN
    , .flags(f32)
`endif
  );

  typedef struct {logic [31:0] x; logic [3:0] f;} res_t;
  res_t q16[$];
  res_t q32[$];
  int   n_chk = 0, n_fail = 0;
  bit   rnd_mode = 1'b0;
  bit   prst[2] = '{1'b0, 1'b0};
  bit   pov[2]  = '{1'b0, 1'b0};
  bit   por[2]  = '{1'b0, 1'b0};
  logic [31:0] px[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Exact integer product of the significands, rounded by remainder vs half-ulp.
  function automatic res_t model(input int ew, input int mw, input logic [31:0] av, input logic [31:0] bv);
    res_t   r;
    longint one = 1;
    longint ua, ub, em, bi, mask, ea, eb, fa, fb, p, e, q, rem, half, sbit;
    int     sh;
    bit     az, ai, an, bz, bin, bn, inex;
    ua = {32'b0, av}; ub = {32'b0, bv};
    em = (one << ew) - 1; bi = (one << (ew - 1)) - 1; mask = (one << mw) - 1;
    ea = (ua >> mw) & em; eb = (ub >> mw) & em;
    fa = ua & mask;       fb = ub & mask;
    sbit = (av[ew+mw] ^ bv[ew+mw]) ? (one << (ew + mw)) : 0;
    az = (ea == 0); ai = (ea == em) && (fa == 0); an = (ea == em) && (fa != 0);
    bz = (eb == 0); bin = (eb == em) && (fb == 0); bn = (eb == em) && (fb != 0);
    r.f = 4'b0000;
    if (an || bn || (ai && bz) || (az && bin)) begin
      r.x = 32'((em << mw) | (one << (mw - 1)));
      r.f = 4'b1000;
    end else if (ai || bin) r.x = 32'(sbit | (em << mw));
    else if (az || bz)      r.x = 32'(sbit);
    else begin
      p  = (fa | (one << mw)) * (fb | (one << mw));
      e  = ea + eb - bi;
      sh = mw;
      if (p >= (one << (2 * mw + 1))) begin sh = mw + 1; e++; end
      q    = p >> sh;
      rem  = p & ((one << sh) - 1);
      half = one << (sh - 1);
      inex = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (one << (mw + 1))) begin q = q >> 1; e++; end
      if (e >= em) begin
        r.x = 32'(sbit | (em << mw)); r.f = 4'b0101;
      end else if (e <= 0) begin
        r.x = 32'(sbit); r.f = 4'b0011;
      end else begin
        r.x = 32'(sbit | (e << mw) | (q & mask)); r.f = {3'b000, inex};
      end
    end
    return r;
  endfunction

  task automatic pin(input string nm, input int ew, input int mw, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] ex, input logic [3:0] ef);
    res_t r;
    r = model(ew, mw, av, bv);
    chk({nm, " x"}, r.x, ex);
    chk({nm, " flags"}, {28'b0, r.f}, {28'b0, ef});
  endtask

  // Transfers are judged at the falling edge, where inputs and outputs are settled.
  task automatic mon(input int id, input logic iv, input logic ir, input logic ov, input logic ordy,
                     input logic [31:0] av, input logic [31:0] bv, input logic [31:0] xv,
                     input logic [3:0] fv);
    string pre;
    res_t  e;
    pre = (id == 0) ? "fp16" : "fp32";
    if (rst) begin
      if (id == 0) q16.delete(); else q32.delete();
      prst[id] = 1'b1; pov[id] = 1'b0;
      return;
    end
    if (prst[id]) begin
      chk({pre, " reset out_valid"}, {31'b0, ov}, 32'd0);
      chk({pre, " reset x"}, xv, 32'd0);
`ifdef FP_MUL_FLAGS_EN
      chk({pre, " reset flags"}, {28'b0, fv}, 32'd0);
`endif
      prst[id] = 1'b0;
    end
    chk({pre, " in_ready"}, {31'b0, ir}, {31'b0, (!ov || ordy)});
    if (pov[id] && !por[id]) begin
      chk({pre, " stall out_valid"}, {31'b0, ov}, 32'd1);
      chk({pre, " stall x"}, xv, px[id]);
    end
    if (ov && ordy) begin
      if ((id == 0 ? q16.size() : q32.size()) == 0) begin
        n_chk++; n_fail++;
        $display("FAIL %s unexpected output: got %h expected none", pre, xv);
      end else begin
        e = (id == 0) ? q16.pop_front() : q32.pop_front();
        chk({pre, " x"}, xv, e.x);
`ifdef FP_MUL_FLAGS_EN
        chk({pre, " flags"}, {28'b0, fv}, {28'b0, e.f});
`endif
      end
    end
    if (iv && ir) begin
      if (id == 0) q16.push_back(model(5, 10, av, bv));
      else         q32.push_back(model(8, 23, av, bv));
    end
    pov[id] = ov; por[id] = ordy; px[id] = xv;
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, iv16, ir16, ov16, or16, {16'b0, a16}, {16'b0, b16}, {16'b0, x16}, f16);
    mon(1, iv32, ir32, ov32, or32, a32, b32, x32, f32);
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_mode) begin
      or16 = ($urandom_range(3) != 0);
      or32 = ($urandom_range(3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input int id, input logic [31:0] av, input logic [31:0] bv);
    int t;
    t = 0;
    if (id == 0) begin a16 = av[15:0]; b16 = bv[15:0]; iv16 = 1'b1; end
    else begin a32 = av; b32 = bv; iv32 = 1'b1; end
    do begin @(negedge clk); t++; end while (!(id == 0 ? ir16 : ir32) && t < 200);
    if (!(id == 0 ? ir16 : ir32)) begin
      n_chk++; n_fail++;
      $display("FAIL send timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    if (id == 0) iv16 = 1'b0; else iv32 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int id);
    int t;
    t = 0;
    while ((id == 0 ? q16.size() : q32.size()) != 0 && t < 300) begin @(posedge clk); t++; end
    idle(2);
    chk(id == 0 ? "fp16 drain pending" : "fp32 drain pending",
        (id == 0 ? q16.size() : q32.size()), 32'd0);
  endtask

  function automatic logic [31:0] rnd16();
    logic [4:0] e;
    if ($urandom_range(1) == 0) return {16'b0, 16'($urandom)};
    e = 5'($urandom_range(8, 22));
    return {16'b0, 1'($urandom), e, 10'($urandom)};
  endfunction

  function automatic logic [31:0] rnd32();
    logic [7:0] e;
    e = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(100, 154));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  logic [31:0] dva[10] = '{32'h3C00, 32'h4000, 32'h3C01, 32'h3C01, 32'h7C00,
                           32'h7C00, 32'h7BFF, 32'h8400, 32'h7E01, 32'h0001};
  logic [31:0] dvb[10] = '{32'h3C00, 32'h4200, 32'h3C01, 32'h3E00, 32'h0000,
                           32'hC000, 32'h7BFF, 32'h3800, 32'h3C00, 32'hBC00};
  logic [31:0] bpa[5]  = '{32'h3C00, 32'h4000, 32'h4200, 32'h3555, 32'hC4A0};
  logic [31:0] bpb[5]  = '{32'h4400, 32'h4000, 32'hC200, 32'h3E66, 32'h4B00};

  initial begin
    int cnt, i, stall, g;
    pin("m 1x1",      5, 10, 32'h3C00, 32'h3C00, 32'h3C00, 4'b0000);
    pin("m 2x3",      5, 10, 32'h4000, 32'h4200, 32'h4600, 4'b0000);
    pin("m rne",      5, 10, 32'h3C01, 32'h3C01, 32'h3C02, 4'b0001);
    pin("m tie",      5, 10, 32'h3C01, 32'h3E00, 32'h3E02, 4'b0001);
    pin("m infxzero", 5, 10, 32'h7C00, 32'h0000, 32'h7E00, 4'b1000);
    pin("m infxneg",  5, 10, 32'h7C00, 32'hC000, 32'hFC00, 4'b0000);
    pin("m ovf",      5, 10, 32'h7BFF, 32'h7BFF, 32'h7C00, 4'b0101);
    pin("m unf",      5, 10, 32'h8400, 32'h3800, 32'h8000, 4'b0011);
    pin("m fp32 pi",  8, 23, 32'h3F800000, 32'h40490FDB, 32'h40490FDB, 4'b0000);

    idle(3);
    rst = 1'b0;
    idle(1);

    a16 = 16'h3C00; b16 = 16'h3C00; iv16 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    iv16 = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!ov16 && cnt < 10);
    chk("fp16 latency", cnt, 32'd3);
    idle(2);

    foreach (dva[k]) send(0, dva[k], dvb[k]);
    drain(0);

    or16 = 1'b0; i = 0; stall = 0; g = 0;
    a16 = bpa[0][15:0]; b16 = bpb[0][15:0]; iv16 = 1'b1;
    while (i < 5 && g < 100) begin
      @(negedge clk);
      g++;
      if (ir16) i++; else stall++;
      @(posedge clk); #1;
      if (stall == 6) or16 = 1'b1;
      if (i < 5) begin a16 = bpa[i][15:0]; b16 = bpb[i][15:0]; end
      else iv16 = 1'b0;
    end
    iv16 = 1'b0; or16 = 1'b1;
    chk("fp16 bp stall cycles", stall, 32'd6);
    chk("fp16 bp accepted", i, 32'd5);
    drain(0);

    rnd_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3) == 0) idle(1);
      send(0, rnd16(), rnd16());
    end
    drain(0);
    rnd_mode = 1'b0;
    idle(1);
    or16 = 1'b1; or32 = 1'b1;

    or16 = 1'b0;
    send(0, 32'h4400, 32'h4400);
    send(0, 32'h4500, 32'h4600);
    send(0, 32'hC000, 32'h3E00);
    rst = 1'b1;
    idle(1);
    rst = 1'b0; or16 = 1'b1;
    idle(10);
    drain(0);

    send(1, 32'h3F800000, 32'h40490FDB);
    send(1, 32'h40000000, 32'h40400000);
    send(1, 32'h7F800000, 32'h00000000);
    send(1, 32'h7F7FFFFF, 32'h40000000);
    drain(1);
    rnd_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3) == 0) idle(1);
      send(1, rnd32(), rnd32());
    end
    drain(1);
    rnd_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier; next generation of the fp16 multiplier block.
- Generalised in exponent/mantissa width. Adds valid/ready flow control, exponent bias correction, product normalisation, round-to-nearest-even, and special-value handling (zero, inf, NaN, overflow, underflow).
- Sits between operand sources and downstream accumulators in the datapath.

Parameters:
- EXP_W, 5, exponent field width (5 gives fp16; 8 with MAN_W=23 gives fp32).
- MAN_W, 10, stored mantissa (fraction) width, hidden bit excluded.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}.
- b  in  1+EXP_W+MAN_W  operand B.
- out_valid  out  1  result x valid.
- out_ready  in  1  downstream accepts x.
- x  out  1+EXP_W+MAN_W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}; present only with FP_MUL_FLAGS_EN.

Behaviour:
- Reset: on a clk edge with rst=1, all stage valid bits clear; out_valid=0, x=0, flags=0.
- Reset mid-operation discards all in-flight operations, with no partial output.
- Pipeline advance: adv = ~out_valid | out_ready. in_ready = adv, combinational.
- All three stages shift together when adv=1 and hold when adv=0.
- Bubbles are not compressed.
- Transfer in occurs on in_valid & in_ready. Transfer out occurs on out_valid & out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- While out_valid=1 and out_ready=0, x and flags are held stable.
- S1 (unpack/classify):
  - sign = sa ^ sb.
  - Each operand is classified ZERO (exp=0; subnormal inputs flushed to zero), INF (exp=all-ones, frac=0), NAN (exp=all-ones, frac≠0) or NORM.
  - Biased exponent sum es = ea + eb - BIAS, computed in EXP_W+2 signed bits, with BIAS = 2^(EXP_W-1)-1.
- S2 (multiply): full (MAN_W+1)x(MAN_W+1) product of {1,frac} operands, giving 2*MAN_W+2 bits. Registered.
- S3 (normalise/round/pack):
  - If product MSB=1, shift right 1 and es+=1.
  - Guard bit = first bit below the kept MAN_W; sticky = OR of all lower bits.
  - Round to nearest, ties to even.
  - If rounding carries out the mantissa, es+=1 and frac=0.
- Result precedence:
  - Any NaN operand, or INF x ZERO: canonical qNaN, sign=0, exp all-ones, frac MSB=1 (0x7E00 for fp16).
  - INF x (INF or NORM): signed infinity.
  - ZERO x (ZERO or NORM): signed zero.
  - es >= 2^EXP_W-1 after rounding: overflow, signed infinity.
  - es <= 0: underflow, flushed to signed zero (no subnormal output).
- Simultaneous in/out transfer in the same cycle is legal and sustains full throughput.

Optional Feature:
- Macro: FP_MUL_FLAGS_EN.
- Defined:
  - The flags port exists and is pipelined alongside x.
  - invalid: NaN operand or INF x ZERO.
  - overflow: finite-operand result rounded beyond the maximum exponent.
  - underflow: nonzero exact result flushed to zero.
  - inexact: guard|sticky, or overflow, or underflow.
- Undefined: no flags port and no flag logic. x behaviour is identical in both cases.

Decomposition:
- Package fp_mul_pkg holds:
  - BIAS and field-width helper functions.
  - Operand class enum {ZERO, NORM, INF, NAN}.
  - Canonical qNaN constant builder.
- One sub-module: fp_round_norm. It is combinational S3 logic covering normalise, RNE, overflow/underflow and pack, parametrised by EXP_W/MAN_W.

Test Plan:
- fp16, out_ready=1: 0x3C00*0x3C00 -> 0x3C00 exactly 3 cycles later. 0x4000*0x4200 -> 0x4600.
- RNE:
  - 0x3C01*0x3C01 -> 0x3C02, inexact=1.
  - Tie case 0x3C01*0x3E00 -> 0x3E02 (513.5 ulp rounds to even).
- Specials:
  - 0x7C00*0x0000 -> 0x7E00, invalid=1.
  - 0x7C00*0xC000 -> 0xFC00.
  - 0x7BFF*0x7BFF -> 0x7C00, overflow=1.
  - 0x8400*0x3800 -> 0x8000, underflow=1.
- Backpressure:
  - Stream 5 operand pairs with out_ready=0. in_ready drops once out_valid=1; x stays stable.
  - Release out_ready: all 5 results emerge in order, none lost or duplicated.
- Reset: assert rst for 1 cycle with 3 ops in flight. Next cycle out_valid=0, x=0, and none of the flushed results ever appear.
- Parameter sweep EXP_W=8, MAN_W=23: 0x3F800000*0x40490FDB -> 0x40490FDB; random normals checked against a reference model with RNE and flush-to-zero.
